// File: rtl/pipe_ctrl_chain_if.sv
// Bundle of the pipeline-backbone signals: per-stage load slices and controls in,
// stage contents, freeze vector, forwarding selects and load-use stall out.
interface pipe_ctrl_chain_if #(
    parameter int DATA_W = 32,
    parameter int STAGES = 4,
    parameter int REG_AW = 5
);
    localparam int SEL_W = $clog2(STAGES + 1);

    logic [STAGES*DATA_W-1:0] nxt_data;
    logic [STAGES*REG_AW-1:0] nxt_dest;
    logic [STAGES-1:0]        nxt_wr;
    logic [STAGES-1:0]        nxt_ld;
    logic                     in_valid;
    logic [STAGES-1:0]        hold_req;
    logic                     flush_en;
    logic [SEL_W-1:0]         flush_cnt;
    logic [REG_AW-1:0]        dec_rs;
    logic [REG_AW-1:0]        dec_rt;
    logic [REG_AW-1:0]        ex_rs;
    logic [REG_AW-1:0]        ex_rt;

    logic [STAGES*DATA_W-1:0] stg_data;
    logic [STAGES*REG_AW-1:0] stg_dest;
    logic [STAGES-1:0]        stg_valid;
    logic [STAGES-1:0]        stg_wr;
    logic [STAGES-1:0]        frz;
    logic [SEL_W-1:0]         fwd_a_sel;
    logic [SEL_W-1:0]         fwd_b_sel;
    logic                     hazard_stall;

    modport master (
        output nxt_data, nxt_dest, nxt_wr, nxt_ld, in_valid, hold_req,
               flush_en, flush_cnt, dec_rs, dec_rt, ex_rs, ex_rt,
        input  stg_data, stg_dest, stg_valid, stg_wr, frz,
               fwd_a_sel, fwd_b_sel, hazard_stall
    );

    modport slave (
        input  nxt_data, nxt_dest, nxt_wr, nxt_ld, in_valid, hold_req,
               flush_en, flush_cnt, dec_rs, dec_rt, ex_rs, ex_rt,
        output stg_data, stg_dest, stg_valid, stg_wr, frz,
               fwd_a_sel, fwd_b_sel, hazard_stall
    );
endinterface

// File: rtl/pipe_ctrl_chain.sv
// Pipeline-register backbone: stage regs with valid, stall chain, bubbles, branch flush,
// hazard detection. Define PIPE_FWD_EN for operand forwarding; otherwise full interlock.
module pipe_ctrl_chain #(
    parameter int DATA_W = 32,
    parameter int STAGES = 4,
    parameter int REG_AW = 5,
    parameter int CONS   = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    pipe_ctrl_chain_if.slave bus
);
    localparam int SEL_W = $clog2(STAGES + 1);

    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];
    logic [REG_AW-1:0] dest_q [STAGES];
    logic [REG_AW-1:0] dest_d [STAGES];
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] wr_q, wr_d;
    logic [STAGES-1:0] ld_q, ld_d;

    logic [STAGES-1:0] frz;
    logic [STAGES-1:0] flush_mask;
    logic [SEL_W-1:0]  fwd_a, fwd_b;
    logic              hazard;

    // A stall in an older stage freezes every younger stage behind it.
    always_comb begin
        frz = '0;
        frz[STAGES-1] = bus.hold_req[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            frz[k] = bus.hold_req[k] | frz[k+1];
        end
    end

    always_comb begin
        flush_mask = '0;
        if (bus.flush_en && (bus.flush_cnt != '0) && (bus.flush_cnt <= SEL_W'(STAGES))) begin
            for (int k = 0; k < STAGES; k++) begin
                flush_mask[k] = (SEL_W'(k) < bus.flush_cnt);
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value before any branch, so no path infers a latch.
        for (int k = 0; k < STAGES; k++) begin
            data_d[k] = data_q[k];
            dest_d[k] = dest_q[k];
        end
        valid_d = valid_q;
        wr_d    = wr_q;
        ld_d    = ld_q;

        if (!frz[0]) begin
            data_d[0]  = bus.nxt_data[0 +: DATA_W];
            dest_d[0]  = bus.nxt_dest[0 +: REG_AW];
            wr_d[0]    = bus.nxt_wr[0];
            ld_d[0]    = bus.nxt_ld[0];
            valid_d[0] = bus.in_valid;
        end

        for (int k = 1; k < STAGES; k++) begin
            if (frz[k]) begin
                valid_d[k] = valid_q[k];
            end else if (frz[k-1]) begin
                valid_d[k] = 1'b0;
                wr_d[k]    = 1'b0;
                ld_d[k]    = 1'b0;
            end else begin
                data_d[k]  = bus.nxt_data[k*DATA_W +: DATA_W];
                dest_d[k]  = bus.nxt_dest[k*REG_AW +: REG_AW];
                wr_d[k]    = bus.nxt_wr[k];
                ld_d[k]    = bus.nxt_ld[k];
                valid_d[k] = valid_q[k-1];
            end
        end

        // Squashed stages keep their payload but lose every control bit.
        for (int k = 0; k < STAGES; k++) begin
            if (flush_mask[k]) begin
                valid_d[k] = 1'b0;
                wr_d[k]    = 1'b0;
                ld_d[k]    = 1'b0;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments, and Reset is tested first so it beats flush and hold.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                dest_q[k] <= '0;
            end
            valid_q <= '0;
            wr_q    <= '0;
            ld_q    <= '0;
        end else begin
            data_q  <= data_d;
            dest_q  <= dest_d;
            valid_q <= valid_d;
            wr_q    <= wr_d;
            ld_q    <= ld_d;
        end
    end

`ifdef PIPE_FWD_EN
    // Scan oldest to youngest so the youngest matching producer is the one kept.
    function automatic logic [SEL_W-1:0] fwd_pick(input logic [REG_AW-1:0] src);
        fwd_pick = '0;
        if (src != '0) begin
            for (int k = STAGES - 1; k > CONS; k--) begin
                if (valid_q[k] && wr_q[k] && (dest_q[k] == src)) begin
                    fwd_pick = SEL_W'(k);
                end
            end
        end
    endfunction

    always_comb begin
        fwd_a  = fwd_pick(bus.ex_rs);
        fwd_b  = fwd_pick(bus.ex_rt);
        hazard = valid_q[CONS] && ld_q[CONS] && wr_q[CONS] && (dest_q[CONS] != '0) &&
                 ((dest_q[CONS] == bus.dec_rs) || (dest_q[CONS] == bus.dec_rt));
    end
`else
    // Without bypassing, any in-flight writer of a decode source must drain first.
    always_comb begin
        fwd_a  = '0;
        fwd_b  = '0;
        hazard = 1'b0;
        for (int k = CONS; k < STAGES; k++) begin
            if (valid_q[k] && wr_q[k] && (dest_q[k] != '0) &&
                ((dest_q[k] == bus.dec_rs) || (dest_q[k] == bus.dec_rt))) begin
                hazard = 1'b1;
            end
        end
    end
`endif

    for (genvar g = 0; g < STAGES; g++) begin : g_pack
        assign bus.stg_data[g*DATA_W +: DATA_W] = data_q[g];
        assign bus.stg_dest[g*REG_AW +: REG_AW] = dest_q[g];
    end

    assign bus.stg_valid    = valid_q;
    assign bus.stg_wr       = wr_q & valid_q;
    assign bus.frz          = frz;
    assign bus.fwd_a_sel    = fwd_a;
    assign bus.fwd_b_sel    = fwd_b;
    assign bus.hazard_stall = hazard;
endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed bench for pipe_ctrl_chain: driver pushes hand-computed expectations into a
// scoreboard queue, a monitor pops and compares them on the falling edge.
module tb_pipe_ctrl_chain;
    localparam int DATA_W = 32;
    localparam int STAGES = 4;
    localparam int REG_AW = 5;
    localparam int CONS   = 1;
`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [127:0] FILL_DATA = 128'h44444444_33333333_22222222_11111111;

    typedef enum {K_VALID, K_DATA, K_DEST, K_WR, K_FRZ, K_FA, K_FB, K_HZ} kind_e;
    typedef struct {
        string        name;
        kind_e        kind;
        logic [127:0] exp;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pipe_ctrl_chain_if #(.DATA_W(DATA_W), .STAGES(STAGES), .REG_AW(REG_AW)) bus ();

    pipe_ctrl_chain #(
        .DATA_W(DATA_W), .STAGES(STAGES), .REG_AW(REG_AW), .CONS(CONS)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] actual_of(input kind_e k);
        case (k)
            K_VALID: actual_of = 128'(bus.stg_valid);
            K_DATA:  actual_of = bus.stg_data;
            K_DEST:  actual_of = 128'(bus.stg_dest);
            K_WR:    actual_of = 128'(bus.stg_wr);
            K_FRZ:   actual_of = 128'(bus.frz);
            K_FA:    actual_of = 128'(bus.fwd_a_sel);
            K_FB:    actual_of = 128'(bus.fwd_b_sel);
            default: actual_of = 128'(bus.hazard_stall);
        endcase
    endfunction

    // Monitor: outputs are settled on the falling edge; compare everything queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check(e.name, actual_of(e.kind), e.exp);
            end
        end
    end

    task automatic expect_v(input string name, input kind_e k, input logic [127:0] v);
        sb_q.push_back('{name: name, kind: k, exp: v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slice(input int k, input logic [31:0] d, input logic [4:0] dst,
                             input logic w, input logic l);
        bus.nxt_data[k*DATA_W +: DATA_W] = d;
        bus.nxt_dest[k*REG_AW +: REG_AW] = dst;
        bus.nxt_wr[k] = w;
        bus.nxt_ld[k] = l;
    endtask

    task automatic fill_slices();
        for (int k = 0; k < STAGES; k++) set_slice(k, 32'h11111111 * (k + 1), 5'd0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.hold_req  = '0;
        bus.flush_en  = 1'b0;
        bus.flush_cnt = '0;
        bus.dec_rs    = '0;
        bus.dec_rt    = '0;
        bus.ex_rs     = '0;
        bus.ex_rt     = '0;
    endtask

    task automatic expect_cleared(input string tag);
        expect_v({tag, "_valid"}, K_VALID, 128'h0);
        expect_v({tag, "_data"},  K_DATA,  128'h0);
        expect_v({tag, "_dest"},  K_DEST,  128'h0);
        expect_v({tag, "_wr"},    K_WR,    128'h0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        for (int k = 0; k < STAGES; k++) set_slice(k, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();

        // Post-reset state
        rst = 1'b0;
        expect_cleared("reset");
        expect_v("reset_frz", K_FRZ, 128'h0);
        expect_v("reset_fa",  K_FA,  128'h0);
        expect_v("reset_fb",  K_FB,  128'h0);
        expect_v("reset_hz",  K_HZ,  128'h0);
        tick();

        // Fill all four stages
        bus.in_valid = 1'b1;
        fill_slices();
        repeat (4) tick();

        // Hold in stage 2: younger stages freeze, stage 3 takes a bubble
        expect_v("fill_valid", K_VALID, 128'hF);
        expect_v("fill_data",  K_DATA,  FILL_DATA);
        bus.hold_req = 4'b0100;
        for (int k = 0; k < STAGES; k++) set_slice(k, 32'hAAAA0000 + k, 5'd0, 1'b0, 1'b0);
        expect_v("hold_frz", K_FRZ, 128'h7);
        tick();

        // Flush the two youngest while stage 0 is held
        expect_v("hold_valid", K_VALID, 128'h7);
        expect_v("hold_data",  K_DATA,  FILL_DATA);
        bus.hold_req  = 4'b0001;
        bus.flush_en  = 1'b1;
        bus.flush_cnt = 3'd2;
        for (int k = 0; k < STAGES; k++) set_slice(k, 32'hF0 + k, 5'd0, 1'b0, 1'b0);
        expect_v("flush_frz", K_FRZ, 128'h1);
        tick();

        // Forwarding setup: stages 1..3 write r8
        expect_v("flush_valid", K_VALID, 128'hC);
        expect_v("flush_data",  K_DATA,  128'h000000F3_000000F2_22222222_11111111);
        idle();
        bus.in_valid = 1'b1;
        set_slice(0, 32'hB0, 5'd0, 1'b0, 1'b0);
        for (int k = 1; k < STAGES; k++) set_slice(k, 32'hB0 + k, 5'd8, 1'b1, 1'b0);
        repeat (4) tick();

        idle();
        bus.hold_req = 4'b1111;
        bus.ex_rs    = 5'd8;
        bus.ex_rt    = 5'd0;
        expect_v("fwd_valid", K_VALID, 128'hF);
        expect_v("fwd_dest",  K_DEST,  128'h42100);
        expect_v("fwd_wr",    K_WR,    128'hE);
        expect_v("fwd_frz",   K_FRZ,   128'hF);
        expect_v("fwd_a_r8",  K_FA,    FWD ? 128'd2 : 128'd0);
        expect_v("fwd_b_r0",  K_FB,    128'd0);
        expect_v("fwd_hz",    K_HZ,    128'd0);
        tick();

        bus.ex_rs  = 5'd5;
        bus.ex_rt  = 5'd8;
        bus.dec_rs = 5'd8;
        expect_v("fwd_a_nomatch", K_FA, 128'd0);
        expect_v("fwd_b_r8",      K_FB, FWD ? 128'd2 : 128'd0);
        expect_v("hz_nonload_r8", K_HZ, FWD ? 128'd0 : 128'd1);
        tick();

        // Load-use: stage 1 loads r9
        idle();
        bus.in_valid = 1'b1;
        set_slice(0, 32'hC0, 5'd0, 1'b0, 1'b0);
        set_slice(1, 32'hC1, 5'd9, 1'b1, 1'b1);
        set_slice(2, 32'hC2, 5'd8, 1'b1, 1'b0);
        set_slice(3, 32'hC3, 5'd8, 1'b1, 1'b0);
        expect_v("lu_pre_hz", K_HZ, 128'd0);
        tick();

        bus.dec_rt   = 5'd9;
        bus.hold_req = 4'b0001;
        set_slice(1, 32'hC1, 5'd9, 1'b1, 1'b1);
        set_slice(2, 32'hC2, 5'd9, 1'b1, 1'b1);
        set_slice(3, 32'hC3, 5'd8, 1'b1, 1'b0);
        expect_v("lu_hz1",  K_HZ,  128'd1);
        expect_v("lu_frz",  K_FRZ, 128'h1);
        tick();

        bus.hold_req = 4'b0000;
        set_slice(0, 32'hD0, 5'd0, 1'b0, 1'b0);
        set_slice(1, 32'hD1, 5'd0, 1'b1, 1'b0);
        set_slice(2, 32'hD2, 5'd0, 1'b0, 1'b0);
        set_slice(3, 32'hD3, 5'd9, 1'b1, 1'b1);
        expect_v("lu_bubble_valid", K_VALID, 128'hD);
        expect_v("lu_hz2",          K_HZ,    FWD ? 128'd0 : 128'd1);
        tick();

        bus.hold_req = 4'b1111;
        bus.ex_rt    = 5'd9;
        expect_v("lu_valid3", K_VALID, 128'hB);
        expect_v("lu_fwd_b",  K_FB,    FWD ? 128'd3 : 128'd0);
        expect_v("lu_hz3",    K_HZ,    FWD ? 128'd0 : 128'd1);
        tick();

        bus.dec_rt = 5'd0;
        bus.ex_rt  = 5'd0;
        expect_v("r0_hz",  K_HZ, 128'd0);
        expect_v("r0_fb",  K_FB, 128'd0);
        expect_v("lu_wr",  K_WR, 128'hA);
        tick();

        // Flush count boundaries
        idle();
        bus.in_valid = 1'b1;
        fill_slices();
        repeat (4) tick();

        expect_v("refill_valid", K_VALID, 128'hF);
        expect_v("refill_data",  K_DATA,  FILL_DATA);
        bus.flush_en  = 1'b1;
        bus.flush_cnt = 3'd0;
        tick();
        expect_v("flush0_valid", K_VALID, 128'hF);
        bus.flush_cnt = 3'd5;
        tick();
        expect_v("flush5_valid", K_VALID, 128'hF);
        bus.flush_cnt = 3'd4;
        tick();
        expect_v("flush4_valid", K_VALID, 128'h0);
        expect_v("flush4_data",  K_DATA,  FILL_DATA);
        bus.flush_en  = 1'b0;
        bus.flush_cnt = 3'd0;
        repeat (4) tick();

        // Mid-run reset with all stages valid
        expect_v("prerst_valid", K_VALID, 128'hF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_cleared("midrst");
        repeat (2) tick();

        // Reset together with flush and full hold
        expect_v("prerst2_valid", K_VALID, 128'h3);
        rst           = 1'b1;
        bus.flush_en  = 1'b1;
        bus.flush_cnt = 3'd2;
        bus.hold_req  = 4'b1111;
        tick();
        rst = 1'b0;
        idle();
        expect_cleared("rstprio");
        tick();

        @(negedge clk);
        #1;
        for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
